// File: rtl/mini_core_cr_mem.sv
// Control-register slave for mini_core: RW display/LED/cursor registers plus
// synchronized switches and debounced buttons, mapped at CR_BASE.
module mini_core_cr_mem #(
    parameter logic [31:0] CR_BASE         = 32'h7000,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    input  logic [3:0]  byte_en,
    output logic [31:0] rd_data,
    input  logic        Button_0,
    input  logic        Button_1,
    input  logic [9:0]  Switch,
    output logic [7:0]  SEG7_0,
    output logic [7:0]  SEG7_1,
    output logic [7:0]  SEG7_2,
    output logic [7:0]  SEG7_3,
    output logic [7:0]  SEG7_4,
    output logic [7:0]  SEG7_5,
    output logic [9:0]  LED,
    output logic [31:0] CURSOR_H,
    output logic [31:0] CURSOR_V
);
    localparam int CW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int NIN = 12;  // {Switch[9:0], Button_1, Button_0}

    logic [31:0] offset;
    logic        hit;
    logic [9:0]  widx;
    logic        unused_ok;

    assign offset    = address - CR_BASE;
    assign hit       = (address >= CR_BASE) && (address <= CR_BASE + 32'hFFF);
    assign widx      = offset[11:2];
    assign unused_ok = ^{offset[31:12], offset[1:0]};

    // Byte-lane merge of store data into an existing 32-bit register.
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int l = 0; l < 4; l++)
            if (be[l]) r[8*l +: 8] = new_v[8*l +: 8];
        return r;
    endfunction

    // ---------------- board input synchronizers ----------------
    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NIN-1:0]                  in_sync;

    // Multi-flop chain on every raw board input.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {Switch, Button_1, Button_0};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    assign in_sync = sync_q[SYNC_STAGES-1];

    // ---------------- button debounce ----------------
    logic [1:0] btn_stable;

    for (genvar b = 0; b < 2; b++) begin : g_db
        logic          btn_q, btn_d;
        logic [CW-1:0] cnt_q, cnt_d;

        // Accept a new level only after it differs from the stable one long enough.
        always_comb begin
            btn_d = btn_q;
            cnt_d = cnt_q;
            if (in_sync[b] == btn_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                btn_d = in_sync[b];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Debounce state register.
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                btn_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                btn_q <= btn_d;
                cnt_q <= cnt_d;
            end
        end

        assign btn_stable[b] = btn_q;
    end

    // ---------------- RW registers and read port ----------------
    logic [5:0][7:0] seg_q, seg_d;
    logic [9:0]      led_q, led_d;
    logic [31:0]     curh_q, curh_d, curv_q, curv_d;
    logic [31:0]     rd_q, rd_d;

    // Store decode: only RW offsets take data, and only on their live lanes.
    always_comb begin
        seg_d  = seg_q;
        led_d  = led_q;
        curh_d = curh_q;
        curv_d = curv_q;
        if (wr_en && hit) begin
            case (widx)
                10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5:
                    if (byte_en[0]) seg_d[widx[2:0]] = wr_data[7:0];
                10'd6: begin
                    if (byte_en[0]) led_d[7:0] = wr_data[7:0];
                    if (byte_en[1]) led_d[9:8] = wr_data[9:8];
                end
                10'd10:  curh_d = merge(curh_q, wr_data, byte_en);
                10'd11:  curv_d = merge(curv_q, wr_data, byte_en);
                default: ;
            endcase
        end
    end

    // Load mux reads pre-write register values; holds when no load is issued.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = '0;
            if (hit) begin
                case (widx)
                    10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5:
                             rd_d = {24'b0, seg_q[widx[2:0]]};
                    10'd6:   rd_d = {22'b0, led_q};
                    10'd7:   rd_d = {31'b0, btn_stable[0]};
                    10'd8:   rd_d = {31'b0, btn_stable[1]};
                    10'd9:   rd_d = {22'b0, in_sync[NIN-1:2]};
                    10'd10:  rd_d = curh_q;
                    10'd11:  rd_d = curv_q;
                    default: rd_d = '0;
                endcase
            end
        end
    end

    // Register file and read data register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            seg_q  <= '0;
            led_q  <= '0;
            curh_q <= '0;
            curv_q <= '0;
            rd_q   <= '0;
        end else begin
            seg_q  <= seg_d;
            led_q  <= led_d;
            curh_q <= curh_d;
            curv_q <= curv_d;
            rd_q   <= rd_d;
        end
    end

    assign rd_data  = rd_q;
    assign SEG7_0   = seg_q[0];
    assign SEG7_1   = seg_q[1];
    assign SEG7_2   = seg_q[2];
    assign SEG7_3   = seg_q[3];
    assign SEG7_4   = seg_q[4];
    assign SEG7_5   = seg_q[5];
    assign LED      = led_q;
    assign CURSOR_H = curh_q;
    assign CURSOR_V = curv_q;
endmodule
